// File: rtl/bcd_sumador_secuencial.sv
// Sequential packed-BCD to binary adder: converts both operands one digit per clock, then adds.
// Optional digit validation is enabled by defining BCD_VALIDA_EN.
module bcd_sumador_secuencial #(
  parameter int unsigned DIGITOS = 2,
  parameter int unsigned ANCHO_N = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*DIGITOS-1:0]   A_bcd,
  input  logic [4*DIGITOS-1:0]   B_bcd,
  output logic                   busy,
  output logic                   done,
  output logic [ANCHO_N-1:0]     N,
  output logic                   err
);

  localparam int unsigned AccW = $clog2(10 ** DIGITOS);
  localparam int unsigned CntW = (DIGITOS > 1) ? $clog2(DIGITOS) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DIGITOS - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StConv = 2'd1;
  localparam logic [1:0] StSuma = 2'd2;

  logic [1:0]           stateQ, stateD;
  logic [4*DIGITOS-1:0] opAQ, opBQ;
  logic [AccW-1:0]      accAQ, accBQ;
  logic [AccW-1:0]      accANext, accBNext;
  logic [CntW-1:0]      cntQ;
  logic [3:0]           digA, digB;
  logic                 doneQ;
  logic [ANCHO_N-1:0]   nQ;

  // Digits are consumed most-significant first, so cnt indexes the current digit.
  assign digA = opAQ[{cntQ, 2'b00} +: 4];
  assign digB = opBQ[{cntQ, 2'b00} +: 4];

  // acc*10 + digit as shift-and-add
  assign accANext = AccW'({accAQ, 3'b000}) + AccW'({accAQ, 1'b0}) + AccW'(digA);
  assign accBNext = AccW'({accBQ, 3'b000}) + AccW'({accBQ, 1'b0}) + AccW'(digB);

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      StIdle:  if (start) stateD = StConv;
      StConv:  if (cntQ == '0) stateD = StSuma;
      StSuma:  stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

`ifdef BCD_VALIDA_EN
  logic flagQ;
  logic errQ;
  logic digitBad;

  assign digitBad = (digA > 4'd9) || (digB > 4'd9);
  assign err      = errQ;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= StIdle;
      opAQ   <= '0;
      opBQ   <= '0;
      accAQ  <= '0;
      accBQ  <= '0;
      cntQ   <= '0;
      doneQ  <= 1'b0;
      nQ     <= '0;
`ifdef BCD_VALIDA_EN
      flagQ  <= 1'b0;
      errQ   <= 1'b0;
`endif
    end else begin
      stateQ <= stateD;
      doneQ  <= (stateQ == StSuma);
      case (stateQ)
        StIdle: begin
          if (start) begin
            opAQ  <= A_bcd;
            opBQ  <= B_bcd;
            accAQ <= '0;
            accBQ <= '0;
            cntQ  <= CntLast;
`ifdef BCD_VALIDA_EN
            flagQ <= 1'b0;
`endif
          end
        end
        StConv: begin
          accAQ <= accANext;
          accBQ <= accBNext;
          if (cntQ != '0) cntQ <= cntQ - 1'b1;
`ifdef BCD_VALIDA_EN
          if (digitBad) flagQ <= 1'b1;
`endif
        end
        StSuma: begin
`ifdef BCD_VALIDA_EN
          if (flagQ) begin
            nQ   <= '0;
            errQ <= 1'b1;
          end else begin
            nQ   <= ANCHO_N'(accAQ) + ANCHO_N'(accBQ);
            errQ <= 1'b0;
          end
`else
          nQ <= ANCHO_N'(accAQ) + ANCHO_N'(accBQ);
`endif
        end
        default: ;
      endcase
    end
  end

  assign busy = (stateQ != StIdle);
  assign done = doneQ;
  assign N    = nQ;

endmodule

// File: tb/tb_bcd_sumador_secuencial.sv
// Scoreboard bench for bcd_sumador_secuencial: a 2-digit and a 3-digit instance checked
// against a decimal-arithmetic reference model.
module tb_bcd_sumador_secuencial;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start2 = 1'b0;
  logic        start3 = 1'b0;
  logic [7:0]  a2 = '0, b2 = '0;
  logic [11:0] a3 = '0, b3 = '0;
  logic        busy2, done2, err2, busy3, done3, err3;
  logic [7:0]  n2;
  logic [10:0] n3;

  always #5 clk = ~clk;

  bcd_sumador_secuencial #(.DIGITOS(2), .ANCHO_N(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .A_bcd(a2), .B_bcd(b2),
    .busy(busy2), .done(done2), .N(n2), .err(err2)
  );

  bcd_sumador_secuencial #(.DIGITOS(3), .ANCHO_N(11)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .A_bcd(a3), .B_bcd(b3),
    .busy(busy3), .done(done3), .N(n3), .err(err3)
  );

  typedef struct {
    int unsigned n;
    int unsigned e;
    int          due;
  } exp_t;

  exp_t q2[$];
  exp_t q3[$];
  exp_t got2, got3;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev2 = 1'b0, prev3 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int unsigned act, input int unsigned want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Decimal value of a packed-BCD word; raw weighting of bad digits, wrapped to the acc width.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input int d,
                                input int w, output int unsigned n, output int unsigned e);
    int unsigned va = 0, vb = 0, p = 1;
    int unsigned accMod;
    bit bad = 0;
    accMod = 1 << $clog2(10 ** d);
    for (int i = 0; i < d; i++) begin
      va += a[4*i +: 4] * p;
      vb += b[4*i +: 4] * p;
      if (a[4*i +: 4] > 9 || b[4*i +: 4] > 9) bad = 1;
      p *= 10;
    end
    va = va % accMod;
    vb = vb % accMod;
    n = (va + vb) % (1 << w);
    e = 0;
`ifdef BCD_VALIDA_EN
    if (bad) begin
      n = 0;
      e = 1;
    end
`endif
  endfunction

  function automatic logic [31:0] randBcd(input int d);
    logic [31:0] v = '0;
    for (int i = 0; i < d; i++) v[4*i +: 4] = 4'($urandom_range(9));
    return v;
  endfunction

  // Monitor: pops the scoreboard whenever a done pulse appears.
  always @(negedge clk) begin
    if (done2) begin
      chk("dut2 done expected", 32'(q2.size() > 0), 1);
      chk("dut2 done single", 32'(prev2), 0);
      chk("dut2 busy low at done", 32'(busy2), 0);
      if (q2.size() > 0) begin
        got2 = q2.pop_front();
        chk("dut2 N", 32'(n2), got2.n);
        chk("dut2 err", 32'(err2), got2.e);
        chk("dut2 latency", cyc, got2.due);
      end
    end
    if (done3) begin
      chk("dut3 done expected", 32'(q3.size() > 0), 1);
      chk("dut3 done single", 32'(prev3), 0);
      if (q3.size() > 0) begin
        got3 = q3.pop_front();
        chk("dut3 N", 32'(n3), got3.n);
        chk("dut3 err", 32'(err3), got3.e);
        chk("dut3 latency", cyc, got3.due);
      end
    end
    prev2 <= done2;
    prev3 <= done3;
  end

  // Called on a negedge; returns on the negedge after the start-sampling edge.
  task automatic issue2(input logic [7:0] a, input logic [7:0] b);
    exp_t x;
    int   guard = 0;
    while (busy2 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("dut2 idle before start", 32'(busy2), 0);
    a2 = a;
    b2 = b;
    start2 = 1'b1;
    model(32'(a), 32'(b), 2, 8, x.n, x.e);
    x.due = cyc + 4;
    q2.push_back(x);
    @(negedge clk);
    start2 = 1'b0;
    a2 = 8'($urandom);
    b2 = 8'($urandom);
  endtask

  task automatic issue3(input logic [11:0] a, input logic [11:0] b);
    exp_t x;
    int   guard = 0;
    while (busy3 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("dut3 idle before start", 32'(busy3), 0);
    a3 = a;
    b3 = b;
    start3 = 1'b1;
    model(32'(a), 32'(b), 3, 11, x.n, x.e);
    x.due = cyc + 5;
    q3.push_back(x);
    @(negedge clk);
    start3 = 1'b0;
    a3 = 12'($urandom);
    b3 = 12'($urandom);
  endtask

  task automatic drain();
    int guard = 0;
    while ((q2.size() != 0 || q3.size() != 0) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("scoreboard drained", 32'(q2.size() + q3.size()), 0);
    @(negedge clk);
  endtask

  initial begin
    #3;
    chk("reset busy", 32'(busy2), 0);
    chk("reset done", 32'(done2), 0);
    chk("reset N", 32'(n2), 0);
    chk("reset err", 32'(err2), 0);
    chk("reset N3", 32'(n3), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue2(8'h45, 8'h37);
    chk("busy in conversion", 32'(busy2), 1);
    issue2(8'h99, 8'h99);
    issue2(8'h00, 8'h00);
    drain();

    // Restart requests while busy must be ignored.
    issue2(8'h23, 8'h11);
    start2 = 1'b1;
    a2 = 8'h98;
    b2 = 8'h76;
    @(negedge clk);
    a2 = 8'h55;
    @(negedge clk);
    start2 = 1'b0;
    drain();

    // Reset in the middle of a conversion abandons it.
    issue2(8'h77, 8'h66);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset busy", 32'(busy2), 0);
    chk("midreset done", 32'(done2), 0);
    chk("midreset N", 32'(n2), 0);
    chk("midreset err", 32'(err2), 0);
    q2.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue2(8'h12, 8'h03);
    drain();

    issue2(8'h4A, 8'h01);
    issue2(8'h10, 8'h10);
    for (int i = 0; i < 20; i++) issue2(8'(randBcd(2)), 8'(randBcd(2)));
    drain();

    // Back-to-back on the 3-digit instance: each start lands in the previous done cycle.
    issue3(12'h999, 12'h999);
    issue3(12'h123, 12'h456);
    for (int i = 0; i < 6; i++) issue3(12'(randBcd(3)), 12'(randBcd(3)));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
